// File: rtl/bitwise_operand_feeder.sv
// Flow-controlled feeder around a combinational 7-bit bitwise operator unit: operand FIFO in, registered result out.
// Optional BW_FEEDER_STATS_EN adds result_cnt and full_seen status outputs.
module bitwise_operand_feeder #(
    parameter int unsigned A_W   = 7,
    parameter int unsigned B_W   = 6,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    output logic [A_W-1:0] op_a,
    output logic [B_W-1:0] op_b,
    input  logic [Y_W-1:0] op_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] out_y
`ifdef BW_FEEDER_STATS_EN
    ,
    output logic [15:0]    result_cnt,
    output logic [0:0]     full_seen
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [A_W-1:0]   r_mem_a [DEPTH];
    logic [B_W-1:0]   r_mem_b [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_load;
    logic             w_empty;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;

    assign w_empty      = (r_count == '0);
    assign in_ready     = (r_count < CNT_W'(DEPTH));
    assign w_push       = in_valid & in_ready;
    assign w_load       = !w_empty & (!out_valid | out_ready);
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    // Head entry drives the operator; zero when nothing is buffered.
    assign op_a = w_empty ? '0 : r_mem_a[r_rd_ptr];
    assign op_b = w_empty ? '0 : r_mem_b[r_rd_ptr];

    // Operand storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_load) begin
                r_rd_ptr  <= w_rd_ptr_nxt;
                out_y     <= op_y;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef BW_FEEDER_STATS_EN
    // Delivered-result counter wraps naturally; full_seen is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_cnt <= '0;
            full_seen  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                result_cnt <= result_cnt + 16'd1;
            end
            if (r_count == CNT_W'(DEPTH)) begin
                full_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_operand_feeder.sv
// Directed bench for bitwise_operand_feeder with a behavioural operator unit and result scoreboard.
// Build with BW_FEEDER_STATS_EN to also exercise result_cnt/full_seen.
module tb_bitwise_operand_feeder;

    localparam int unsigned A_W   = 7;
    localparam int unsigned B_W   = 6;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic [A_W-1:0] op_a;
    logic [B_W-1:0] op_b;
    logic [Y_W-1:0] op_y;
    logic           out_valid;
    logic           out_ready;
    logic [Y_W-1:0] out_y;
`ifdef BW_FEEDER_STATS_EN
    logic [15:0]    result_cnt;
    logic [0:0]     full_seen;
`endif

    logic [2:0]     tb_op;
    int             n_checks = 0;
    int             n_errors = 0;
    int             n_out    = 0;
    logic [Y_W-1:0] exp_q [$];

    bitwise_operand_feeder #(
        .A_W(A_W), .B_W(B_W), .Y_W(Y_W), .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_y      (op_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
`ifdef BW_FEEDER_STATS_EN
        ,
        .result_cnt(result_cnt),
        .full_seen (full_seen)
`endif
    );

    always #5 clk = ~clk;

    // Reference operator: B zero-extended, op 0..6 = AND OR NAND NOR XOR XNOR NOT(A).
    function automatic logic [Y_W-1:0] bw_unit(input logic [2:0] op, input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b);
        logic [Y_W-1:0] bz;
        bz = Y_W'(b);
        case (op)
            3'd0:    return a & bz;
            3'd1:    return a | bz;
            3'd2:    return ~(a & bz);
            3'd3:    return ~(a | bz);
            3'd4:    return a ^ bz;
            3'd5:    return ~(a ^ bz);
            default: return ~a;
        endcase
    endfunction

    always_comb op_y = bw_unit(tb_op, op_a, op_b);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes seen mid-cycle complete on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check_eq("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("sb_result", 32'(out_y), 32'(exp_q.pop_front()));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(bw_unit(tb_op, in_a, in_b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int pushed;
        int cyc;
        int start_out;
        logic acc;
        logic ok_rdy;
        logic ok_thr;

        rst = 1'b1; in_valid = 1'b1; in_a = 7'h11; in_b = 6'h22; out_ready = 1'b0; tb_op = 3'd4;

        // Reset held two cycles with in_valid asserted.
        step(); step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_y",     32'(out_y),     32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_op_a",      32'(op_a),      32'd0);
        check_eq("rst_op_b",      32'(op_b),      32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        // Single pass, XOR: 55 ^ 2A = 7F.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 7'h55; in_b = 6'h2A;
        step();
        in_valid = 1'b0;
        check_eq("single_op_a",  32'(op_a),      32'h55);
        check_eq("single_op_b",  32'(op_b),      32'h2A);
        check_eq("single_nvld",  32'(out_valid), 32'd0);
        step();
        check_eq("single_vld",   32'(out_valid), 32'd1);
        check_eq("single_y",     32'(out_y),     32'h7F);
        step();
        check_eq("single_drop",  32'(out_valid), 32'd0);
        check_eq("single_hold",  32'(out_y),     32'h7F);

        // Backpressure, AND: five pairs, one lands in out_y, four fill the FIFO.
        tb_op = 3'd0; out_ready = 1'b0;
        in_valid = 1'b1; in_a = 7'h7F; in_b = 6'h3F; step();
        in_a = 7'h0F; in_b = 6'h3C; step();
        in_a = 7'h70; in_b = 6'h15; step();
        in_a = 7'h55; in_b = 6'h2A; step();
        in_a = 7'h01; in_b = 6'h01; step();
        in_a = 7'h02; in_b = 6'h02;
        check_eq("bp_full_rdy",  32'(in_ready),  32'd0);
        check_eq("bp_vld",       32'(out_valid), 32'd1);
        check_eq("bp_y",         32'(out_y),     32'h3F);
        step(); step();
        check_eq("bp_still_full", 32'(in_ready), 32'd0);
        check_eq("bp_y_stable",  32'(out_y),     32'h3F);
        check_eq("bp_head_a",    32'(op_a),      32'h0F);
        check_eq("bp_head_b",    32'(op_b),      32'h3C);
`ifdef BW_FEEDER_STATS_EN
        check_eq("bp_full_seen", 32'(full_seen), 32'd1);
`endif
        in_valid = 1'b0; out_ready = 1'b1;
        step(); check_eq("bp_r1", 32'(out_y), 32'h0C); check_eq("bp_v1", 32'(out_valid), 32'd1);
        step(); check_eq("bp_r2", 32'(out_y), 32'h10); check_eq("bp_v2", 32'(out_valid), 32'd1);
        step(); check_eq("bp_r3", 32'(out_y), 32'h00); check_eq("bp_v3", 32'(out_valid), 32'd1);
        step(); check_eq("bp_r4", 32'(out_y), 32'h01); check_eq("bp_v4", 32'(out_valid), 32'd1);
        step();
        check_eq("bp_drained",   32'(out_valid), 32'd0);
        check_eq("bp_y_retain",  32'(out_y),     32'h01);

        // Streaming, OR: a=b=i gives result i, one per cycle.
        tb_op = 3'd1; out_ready = 1'b1;
        start_out = n_out; ok_rdy = 1'b1; ok_thr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_a = A_W'(i); in_b = B_W'(i);
            ok_rdy &= in_ready;
            step();
            if (i >= 1) ok_thr &= out_valid;
        end
        in_valid = 1'b0;
        step(); step(); step();
        check_eq("stream_rdy",   32'(ok_rdy),          32'd1);
        check_eq("stream_thru",  32'(ok_thr),          32'd1);
        check_eq("stream_count", 32'(n_out - start_out), 32'd20);
        check_eq("stream_last",  32'(out_y),           32'd19);

        // Wrap, XNOR: 3 x DEPTH random pushes under random backpressure.
        tb_op = 3'd5; pushed = 0; cyc = 0;
        while (pushed < 3 * DEPTH && cyc < 300) begin
            in_valid = 1'b1; in_a = A_W'($urandom); in_b = B_W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            acc = in_ready;
            step();
            if (acc) pushed++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_eq("wrap_pushed", 32'(pushed), 32'(3 * DEPTH));
        cyc = 0;
        while ((out_valid || exp_q.size() != 0) && cyc < 20) begin
            step();
            cyc++;
        end
        check_eq("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("wrap_idle",     32'(out_valid),     32'd0);
`ifdef BW_FEEDER_STATS_EN
        out_ready = 1'b0;
        step();
        check_eq("stats_cnt", 32'(result_cnt), 32'(n_out & 32'hFFFF));
`endif

        // Mid-operation reset with FIFO full and a result held.
        tb_op = 3'd0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = A_W'(i + 1); in_b = B_W'(i + 2);
            step();
        end
        in_valid = 1'b0;
        step();
        check_eq("mr_full",  32'(in_ready),  32'd0);
        check_eq("mr_vld",   32'(out_valid), 32'd1);
        rst = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check_eq("mr_vld0",  32'(out_valid), 32'd0);
        check_eq("mr_y0",    32'(out_y),     32'd0);
        check_eq("mr_rdy",   32'(in_ready),  32'd1);
        check_eq("mr_op_a",  32'(op_a),      32'd0);
        check_eq("mr_op_b",  32'(op_b),      32'd0);
`ifdef BW_FEEDER_STATS_EN
        check_eq("mr_cnt0",  32'(result_cnt), 32'd0);
        check_eq("mr_full0", 32'(full_seen),  32'd0);
`endif
        out_ready = 1'b1;
        ok_thr = 1'b0;
        repeat (3) begin
            step();
            ok_thr |= out_valid;
        end
        check_eq("mr_no_stale", 32'(ok_thr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
